// File: rtl/mod_74x08_2.sv
// Two-input AND slice of a 74x08: Y[i] = A[i] & B[i], vector or per-gate build, optional output register.
// Latency 0 (combinational) or 1 clk (REGISTERED); no backpressure, Y is overwritten every evaluation/edge.
module mod_74x08_2 #(
    parameter int GATES      = 2,
    parameter int IMPL_SPLIT = 0,
    parameter int REGISTERED = 0,
    parameter int TPD        = 0
) (
    input  logic [0:GATES-1] A,
    input  logic [0:GATES-1] B,
    output logic [0:GATES-1] Y,
    input  logic             clk,
    input  logic             rst_n
);

    logic [0:GATES-1] and_y;

    if (GATES < 1 || GATES > 4) begin : g_bad_gates
        $error("mod_74x08_2: GATES=%0d is outside the legal range 1..4", GATES);
    end

    // TPD only shapes behavioural board models; the synthesizable netlist is zero-delay.
    if (TPD < 0) begin : g_bad_tpd
        $error("mod_74x08_2: TPD=%0d must not be negative", TPD);
    end

    if (IMPL_SPLIT != 0) begin : g_split
        for (genvar i = 0; i < GATES; i++) begin : g_gate
            assign and_y[i] = A[i] & B[i];
        end
    end else begin : g_vec
        assign and_y = A & B;
    end

    if (REGISTERED != 0) begin : g_reg
        logic [0:GATES-1] y_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y_q <= '0;
            end else begin
                y_q <= and_y;
            end
        end

        assign Y = y_q;
    end else begin : g_comb
        // clk/rst_n may float in this build; they are deliberately kept out of the Y path.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign Y = and_y;
    end

endmodule

// File: tb/tb_mod_74x08_2.sv
// Directed bench for mod_74x08_2: combinational vector/split builds plus registered builds,
// checked against literal expectations and a per-cycle reference model.
module tb_mod_74x08_2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [0:1] a     = 2'b00;
    logic [0:1] b     = 2'b00;
    logic [0:1] y_vec, y_spl, y_rvec, y_rspl;
    wire        float_clk = 1'bz;
    wire        float_rst = 1'bz;

    int errors = 0;
    int checks = 0;
    bit run_chk = 1'b0;

    // Reference for the registered builds: the value seen at the last rising edge,
    // valid only if reset was high at that edge and has not been asserted since.
    bit         model_vld = 1'b0;
    logic [0:1] model_q   = 2'b00;

    logic [0:1] tv_a [6] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01};
    logic [0:1] tv_b [6] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11};
    logic [0:1] tv_y [6] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};

    always #10 clk = ~clk;

    mod_74x08_2 #(.GATES(2), .IMPL_SPLIT(0), .REGISTERED(0)) u_vec (
        .A(a), .B(b), .Y(y_vec), .clk(float_clk), .rst_n(float_rst)
    );
    mod_74x08_2 #(.GATES(2), .IMPL_SPLIT(1), .REGISTERED(0)) u_spl (
        .A(a), .B(b), .Y(y_spl), .clk(clk), .rst_n(rst_n)
    );
    mod_74x08_2 #(.GATES(2), .IMPL_SPLIT(0), .REGISTERED(1)) u_rvec (
        .A(a), .B(b), .Y(y_rvec), .clk(clk), .rst_n(rst_n)
    );
    mod_74x08_2 #(.GATES(2), .IMPL_SPLIT(1), .REGISTERED(1)) u_rspl (
        .A(a), .B(b), .Y(y_rspl), .clk(clk), .rst_n(rst_n)
    );

    task automatic chk(input string name, input logic [0:1] act, input logic [0:1] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [0:1] na, input logic [0:1] nb);
        @(posedge clk);
        #2;
        a = na;
        b = nb;
    endtask

    always @(posedge clk) begin
        model_vld = rst_n;
        model_q   = a & b;
    end

    always @(negedge rst_n) model_vld = 1'b0;

    always @(negedge clk) begin
        if (run_chk) begin
            chk("model_vec",  y_vec,  a & b);
            chk("model_spl",  y_spl,  a & b);
            chk("model_rvec", y_rvec, model_vld ? model_q : 2'b00);
            chk("model_rspl", y_rspl, model_vld ? model_q : 2'b00);
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #4;
        chk("reset_rvec", y_rvec, 2'b00);
        chk("reset_rspl", y_rspl, 2'b00);
        run_chk = 1'b1;

        // Basic truth table and gate independence, with the registered builds held in reset.
        for (int i = 0; i < 6; i++) begin
            step(tv_a[i], tv_b[i]);
            #5;
            chk("scen_vec", y_vec, tv_y[i]);
            chk("scen_spl", y_spl, tv_y[i]);
            chk("scen_rvec_in_reset", y_rvec, 2'b00);
        end

        for (int i = 0; i < 16; i++) begin
            step(i[3:2], i[1:0]);
            #5;
            chk("sweep_equiv", y_spl, y_vec);
            chk("sweep_rspl_equiv", y_rspl, y_rvec);
        end

        // One-cycle latency after reset release.
        step(2'b00, 2'b00);
        @(posedge clk);
        #5 rst_n = 1'b1;
        step(2'b11, 2'b11);
        #5;
        chk("lat_before_edge", y_rvec, 2'b00);
        @(posedge clk);
        #1;
        chk("lat_after_edge_vec", y_rvec, 2'b11);
        chk("lat_after_edge_spl", y_rspl, 2'b11);
        #1;
        a = 2'b00;
        #5;
        chk("lat_hold", y_rvec, 2'b11);
        @(posedge clk);
        #1;
        chk("lat_clear", y_rvec, 2'b00);

        // Asynchronous reset between edges, hold during reset, load on first edge after release.
        step(2'b11, 2'b11);
        @(posedge clk);
        #5;
        chk("pre_reset", y_rvec, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("async_clear_vec", y_rvec, 2'b00);
        chk("async_clear_spl", y_rspl, 2'b00);
        a = 2'b01;
        b = 2'b11;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("hold_in_reset", y_rvec, 2'b00);
        end
        #4 rst_n = 1'b1;
        #1;
        chk("release_no_edge", y_rvec, 2'b00);
        @(posedge clk);
        #1;
        chk("release_load_vec", y_rvec, 2'b01);
        chk("release_load_spl", y_rspl, 2'b01);

        repeat (2) @(posedge clk);
        #1;
        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
